// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MEM stage load/store port.
// A request is accepted from IDLE, serviced after LATENCY edges with a one-cycle
// ack_o pulse, and flagged with err_o if misaligned or out of range.
// Optional feature macro: DMEM_BYTE_STROBE_EN (adds be_i and byte-masked stores).
// Ports:
//   clk_i, rst_i    clock, asynchronous active-low reset
//   req_i, we_i     request valid (held until ack_o), 1 = store / 0 = load
//   addr_i          byte address
//   wdata_i         store data
//   be_i            byte strobes (only with DMEM_BYTE_STROBE_EN)
//   ack_o           one-cycle completion pulse
//   rdata_o         load data, held until the next load or error response
//   err_o           qualifies ack_o, 1 = request rejected
//   busy_o          request in flight (WAIT or RESP), pipeline stall source
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               lat_en;

    logic               ack_d, err_d, busy_d;
    logic [31:0]        rdata_d;

    logic               sel_we;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_be;
    logic [IDX_W-1:0]   sel_idx;
    logic               addr_err;
    logic [31:0]        wr_word;
    logic               mem_we;

    logic [31:0]        mem [DEPTH_WORDS];

    // Request fields: live inputs at the acceptance edge (LATENCY=1 enters RESP
    // directly from IDLE), latched copies once the request is in flight.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_we    = we_i;
            sel_addr  = addr_i;
            sel_wdata = wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
            sel_be    = be_i;
`else
            sel_be    = 4'hF;
`endif
        end else begin
            sel_we    = we_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
            sel_be    = be_q;
        end
    end

    assign sel_idx  = sel_addr[IDX_W+1:2];
    assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH_WORDS));

    // Store word: unstrobed bytes keep the current array contents.
    always_comb begin
        wr_word = mem[sel_idx];
        for (int b = 0; b < 4; b++) begin
            if (sel_be[b]) begin
                wr_word[8*b +: 8] = sel_wdata[8*b +: 8];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_en  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_o;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    lat_en = 1'b1;
                    cnt_d  = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion work happens on the edge that enters RESP.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            ack_d = 1'b1;
            err_d = addr_err;
            if (addr_err) begin
                rdata_d = '0;
            end else if (sel_we) begin
                mem_we = |sel_be;
            end else begin
                rdata_d = mem[sel_idx];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, countdown and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= ack_d;
            err_o   <= err_d;
            busy_o  <= busy_d;
            rdata_o <= rdata_d;
        end
    end

    // Request field capture at acceptance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (lat_en) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= be_i;
`else
            be_q    <= 4'hF;
`endif
        end
    end

    // Storage array, never reset; the rst_i qualifier drops a commit that
    // coincides with reset assertion.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_i) begin
            mem[sel_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases from the plan plus
// randomized loads/stores against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LAT     = 3;
    localparam int unsigned NWORDS  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, err, busy;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] model_mem [NWORDS];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .be_i    (be),
`endif
        .ack_o   (ack),
        .rdata_o (rdata),
        .err_o   (err),
        .busy_o  (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // One complete transaction from IDLE, checked for latency, flags and data.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] strobes);
        int n;
        logic [3:0] eff_be;
        logic e;
`ifdef DMEM_BYTE_STROBE_EN
        eff_be = strobes;
`else
        eff_be = 4'hF;
`endif
        e = is_err(a);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = strobes;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_latency", 32'(n), 32'(LAT));
        check("err_flag", 32'(err), 32'(e));
        if (e) begin
            exp_rdata = 32'h0;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (eff_be[b]) model_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            exp_rdata = model_mem[a[5:2]];
        end
        check(w ? "rdata_after_store" : "rdata_load", rdata, exp_rdata);
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("busy_released", 32'(busy), 32'd0);
    endtask

    task automatic pick_addr(output logic [31:0] a);
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r <= 6)      a = 32'($urandom_range(0, NWORDS - 1)) << 2;
        else if (r == 7) a = (32'($urandom_range(0, NWORDS - 1)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'h400 + (32'($urandom_range(0, 63)) << 2);
        else             a = ($urandom() | 32'h1000_0000) & 32'hFFFF_FFFC;
    endtask

    initial begin
        logic [31:0] a;
        int t_ack [3];
        int n;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
        exp_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Quiet after reset.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end

        // Store then load same address.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        check("load_deadbeef", rdata, 32'hDEADBEEF);

        // Fill the modelled region with known data.
        for (int i = 0; i < int'(NWORDS); i++)
            xfer(1'b1, 32'(i) << 2, $urandom(), 4'hF);

        // Error cases.
        xfer(1'b0, 32'h13, 32'h0, 4'hF);
        xfer(1'b0, 32'h400, 32'h0, 4'hF);
        xfer(1'b1, 32'h402, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < int'(NWORDS); i++)
            xfer(1'b0, 32'(i) << 2, 32'h0, 4'hF);

        // Reset in WAIT aborts a store.
        xfer(1'b1, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        req = 1'b0;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        check("abort_no_ack", 32'(n), 32'd0);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        check("abort_rdata_reset", rdata, 32'h0);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);
        check("abort_word_kept", rdata, 32'h0);

        // req held high for three back-to-back loads.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!ack && n < 20);
            check("held_ack_seen", 32'(ack), 32'd1);
            t_ack[k] = cyc;
            exp_rdata = model_mem[k];
            check("held_rdata", rdata, exp_rdata);
            addr = 32'(k + 1) << 2;
        end
        req = 1'b0;
        check("held_spacing_01", 32'(t_ack[1] - t_ack[0]), 32'(LAT + 2));
        check("held_spacing_12", 32'(t_ack[2] - t_ack[1]), 32'(LAT + 2));
        @(posedge clk); #1;
        check("held_ack_drop", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("held_idle", 32'(busy), 32'd0);

`ifdef DMEM_BYTE_STROBE_EN
        xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        xfer(1'b1, 32'h20, 32'h11223344, 4'b0101);
        xfer(1'b0, 32'h20, 32'h0, 4'hF);
        check("strobe_merge", rdata, 32'hAA22CC44);
        xfer(1'b1, 32'h20, 32'h55667788, 4'b0000);
        xfer(1'b0, 32'h20, 32'h0, 4'b0000);
        check("strobe_none", rdata, 32'hAA22CC44);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            pick_addr(a);
            xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
